// File: rtl/systolic_feeder.sv
// Feeds a systolic_vector array. It loads one weight tile over the weight stream,
// then streams feature vectors with lane i delayed by i cycles.
//
// state  | meaning
// IDLE   | waiting for start_in; no ready outputs
// LOAD_W | accepting ROW weight words, shifting them into the PE chain
// FEED   | accepting feature vectors into the skew delay lines
// DRAIN  | flushing the skew with zeros for ROW-1 cycles, then done_out
module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int ROW   = 2
) (
  input  logic             clk_in1,
  input  logic             rst_in1,
  input  logic             start_in,
  input  logic             w_valid_in,
  input  logic [WIDTH-1:0] w_data_in,
  output logic             w_ready_out,
  input  logic             f_valid_in,
  input  logic [WIDTH-1:0] f_data_in [ROW-1:0],
  input  logic             f_last_in,
  output logic             f_ready_out,
  output logic             ctrl_out1,
  output logic [WIDTH-1:0] weight_out1,
  output logic [WIDTH-1:0] feature_out [ROW-1:0],
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [1:0] {IDLE, LOAD_W, FEED, DRAIN} state_t;

  localparam int CW = $clog2(ROW + 1);
  localparam logic [CW-1:0] W_LAST = CW'(ROW - 1);
  localparam logic [CW-1:0] D_LOAD = CW'((ROW > 1) ? ROW - 2 : 0);

  state_t          state, state_nx;
  logic [CW-1:0]   w_cnt, w_cnt_nx;
  logic [CW-1:0]   d_cnt, d_cnt_nx;
  logic            w_hs, f_hs, done_nx;
  logic [WIDTH-1:0] lane_in [ROW-1:0];

  assign w_ready_out = (state == LOAD_W);
  assign f_ready_out = (state == FEED);
  assign busy_out    = (state != IDLE);
  assign w_hs        = w_valid_in && w_ready_out;
  assign f_hs        = f_valid_in && f_ready_out;

  always_comb begin
    state_nx = state;
    w_cnt_nx = w_cnt;
    d_cnt_nx = d_cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_nx = LOAD_W;
          w_cnt_nx = '0;
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          w_cnt_nx = w_cnt + CW'(1);
          if (w_cnt == W_LAST) state_nx = FEED;
        end
      end
      FEED: begin
        if (f_hs && f_last_in) begin
          if (ROW > 1) begin
            state_nx = DRAIN;
            d_cnt_nx = D_LOAD;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      DRAIN: begin
        // down-counter; terminal count ends the tile
        if (d_cnt == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          d_cnt_nx = d_cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or posedge rst_in1) begin
    if (rst_in1) begin
      state       <= IDLE;
      w_cnt       <= '0;
      d_cnt       <= '0;
      ctrl_out1   <= 1'b0;
      weight_out1 <= '0;
      done_out    <= 1'b0;
    end else begin
      state       <= state_nx;
      w_cnt       <= w_cnt_nx;
      d_cnt       <= d_cnt_nx;
      ctrl_out1   <= w_hs;
      weight_out1 <= w_hs ? w_data_in : '0;
      done_out    <= done_nx;
    end
  end

  // Zeros enter every lane unless a vector is accepted, which keeps the skew intact.
  always_comb begin
    for (int i = 0; i < ROW; i++) begin
      lane_in[i] = f_hs ? f_data_in[i] : '0;
    end
  end

  for (genvar i = 0; i < ROW; i++) begin : g_lane
    logic [WIDTH-1:0] taps [i+1];

    always_ff @(posedge clk_in1 or posedge rst_in1) begin
      if (rst_in1) begin
        for (int k = 0; k <= i; k++) taps[k] <= '0;
      end else begin
        taps[0] <= lane_in[i];
        for (int k = 1; k <= i; k++) taps[k] <= taps[k-1];
      end
    end

    assign feature_out[i] = taps[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed tile scenarios followed by random traffic,
// checked every cycle against a timeline model of accepted weights and vectors.
module tb_systolic_feeder;
  localparam int WIDTH = 8;
  localparam int ROW   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             w_valid = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             w_ready;
  logic             f_valid = 1'b0;
  logic [WIDTH-1:0] f_data [1:0];
  logic             f_last = 1'b0;
  logic             f_ready;
  logic             ctrl;
  logic [WIDTH-1:0] weight;
  logic [WIDTH-1:0] feat [1:0];
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;

  // model: phase 0 idle, 1 weight load, 2 feed, 3 drain
  int ph, wc, dr, t;
  logic [WIDTH-1:0] hist [0:4095][0:1];

  systolic_feeder #(.WIDTH(WIDTH), .ROW(ROW)) dut (
    .clk_in1(clk), .rst_in1(rst), .start_in(start),
    .w_valid_in(w_valid), .w_data_in(w_data), .w_ready_out(w_ready),
    .f_valid_in(f_valid), .f_data_in(f_data), .f_last_in(f_last), .f_ready_out(f_ready),
    .ctrl_out1(ctrl), .weight_out1(weight), .feature_out(feat),
    .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at t=%0d", tag, obs, expv, t);
    end
  endtask

  task automatic chk8(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at t=%0d", tag, obs, expv, t);
    end
  endtask

  task automatic model_reset();
    ph = 0; wc = 0; dr = 0; t = 0;
    for (int c = 0; c < 4096; c++) begin
      hist[c][0] = '0;
      hist[c][1] = '0;
    end
  endtask

  task automatic chk_all_zero();
    chk1("rst_ctrl", ctrl, 1'b0);
    chk8("rst_weight", weight, '0);
    chk8("rst_feat0", feat[0], '0);
    chk8("rst_feat1", feat[1], '0);
    chk1("rst_w_ready", w_ready, 1'b0);
    chk1("rst_f_ready", f_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic cyc(input logic st, input logic wv, input logic [WIDTH-1:0] wd,
                     input logic fv, input logic [WIDTH-1:0] f0, input logic [WIDTH-1:0] f1,
                     input logic fl);
    logic w_hs, f_hs, d;
    start = st; w_valid = wv; w_data = wd;
    f_valid = fv; f_data[0] = f0; f_data[1] = f1; f_last = fl;
    chk1("w_ready", w_ready, ph == 1);
    chk1("f_ready", f_ready, ph == 2);
    chk1("busy", busy, ph != 0);
    w_hs = (ph == 1) && wv;
    f_hs = (ph == 2) && fv;
    d = 1'b0;
    case (ph)
      0: if (st) begin ph = 1; wc = 0; end
      1: if (w_hs) begin wc++; if (wc == ROW) ph = 2; end
      2: if (f_hs && fl) begin
           if (ROW > 1) begin ph = 3; dr = ROW - 1; end
           else begin ph = 0; d = 1'b1; end
         end
      3: begin dr--; if (dr == 0) begin ph = 0; d = 1'b1; end end
      default: ph = 0;
    endcase
    t++;
    hist[t][0] = f_hs ? f0 : '0;
    hist[t][1] = f_hs ? f1 : '0;
    @(posedge clk);
    #1;
    chk1("ctrl", ctrl, w_hs);
    chk8("weight", weight, w_hs ? wd : '0);
    chk1("done", done, d);
    chk8("feat0", feat[0], hist[t][0]);
    chk8("feat1", feat[1], hist[t-1][1]);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1 chk_all_zero();
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    f_data[0] = '0;
    f_data[1] = '0;
    model_reset();
    #3 chk_all_zero();
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    // weight load with w_valid already high on the start cycle
    cyc(1, 1, 8'h09, 0, '0, '0, 0);
    cyc(0, 1, 8'h01, 0, '0, '0, 0);
    cyc(0, 1, 8'h04, 0, '0, '0, 0);
    // skewed feed [1,0], [1,5], [0,2] last
    cyc(0, 0, '0, 1, 8'h01, 8'h00, 0);
    cyc(0, 0, '0, 1, 8'h01, 8'h05, 0);
    cyc(0, 0, '0, 1, 8'h00, 8'h02, 1);
    cyc(0, 0, '0, 1, 8'hee, 8'hee, 0);

    // back-to-back start, weight stalls with a start pulse while loading
    cyc(1, 0, '0, 0, '0, '0, 0);
    cyc(0, 1, 8'h11, 0, '0, '0, 0);
    cyc(1, 0, 8'h22, 0, '0, '0, 0);
    cyc(0, 1, 8'h33, 1, 8'haa, 8'hbb, 0);
    // feed with a bubble carrying a start pulse
    cyc(0, 0, '0, 1, 8'h01, 8'h00, 0);
    cyc(0, 0, '0, 1, 8'h01, 8'h05, 0);
    cyc(1, 0, '0, 0, 8'h77, 8'h77, 0);
    cyc(0, 0, '0, 1, 8'h00, 8'h02, 1);
    idle(3);

    // reset after the 2nd vector, then a clean single-vector tile
    cyc(1, 0, '0, 0, '0, '0, 0);
    cyc(0, 1, 8'h5a, 0, '0, '0, 0);
    cyc(0, 1, 8'ha5, 0, '0, '0, 0);
    cyc(0, 0, '0, 1, 8'h12, 8'h34, 0);
    cyc(0, 0, '0, 1, 8'h56, 8'h78, 0);
    reset_mid();
    cyc(1, 0, '0, 0, '0, '0, 0);
    cyc(0, 1, 8'hc3, 0, '0, '0, 0);
    cyc(0, 1, 8'h3c, 0, '0, '0, 0);
    cyc(0, 0, '0, 1, 8'h7f, 8'h80, 1);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
          $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
          $urandom_range(0, 3) == 0);
      if (n == 200) reset_mid();
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
